// File: rtl/stopwatch_ctrl.sv
//------------------------------------------------------------------------------
// stopwatch_ctrl
//
// Stopwatch sequencer for the two-digit display counter. Debounced button
// levels are edge-detected and drive an IDLE / RUN / PAUSE state machine with
// a lap (display freeze) overlay. The main clock is divided into count ticks.
// Each tick advances a two-digit counter whose digits wrap at DIGIT_MAX. The
// digit outputs feed the binary-to-7-segment decoders.
//
// Parameters
//   TICK_DIV   clock cycles per count tick, 2 .. 2**24
//   DIGIT_MAX  last value of each digit before it wraps (9 decimal, 15 hex)
//
// Ports
//   clock       in   main clock
//   reset_n     in   asynchronous active-low reset
//   start_stop  in   debounced level; a rising edge toggles start / pause
//   clear       in   debounced level; a rising edge requests a clear
//   lap         in   debounced level; a rising edge toggles the lap freeze
//   digit_lo    out  displayed low digit
//   digit_hi    out  displayed high digit
//   running     out  high while in RUN
//   lap_active  out  high while the display is frozen
//   tick        out  one-cycle pulse on each count increment
//
// Every output comes straight from a flop. There is no combinational path
// from the inputs to the outputs.
//------------------------------------------------------------------------------
module stopwatch_ctrl #(
   parameter int unsigned TICK_DIV  = 2500000,
   parameter int unsigned DIGIT_MAX = 9
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       start_stop,
   input  logic       clear,
   input  logic       lap,
   output logic [3:0] digit_lo,
   output logic [3:0] digit_hi,
   output logic       running,
   output logic       lap_active,
   output logic       tick
);

   localparam int unsigned     PS_W    = $clog2(TICK_DIV);
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
   localparam logic [3:0]      D_MAX   = 4'(DIGIT_MAX);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   typedef struct packed {
      logic [3:0] hi;
      logic [3:0] lo;
   } count_t;

   // Increment one step: the low digit first; on its wrap, carry into the
   // high digit. Both digits at DIGIT_MAX roll over to 00.
   function automatic count_t next_count(input count_t c);
      count_t n;
      n = c;
      if (c.lo < D_MAX) begin
         n.lo = c.lo + 4'd1;
      end else begin
         n.lo = 4'd0;
         if (c.hi < D_MAX) begin
            n.hi = c.hi + 4'd1;
         end else begin
            n.hi = 4'd0;
         end
      end
      return n;
   endfunction

   state_t          state_q, state_d;
   logic            ss_prev, clr_prev, lap_prev;
   logic            ss_ev, clr_ev, lap_ev;
   logic [PS_W-1:0] ps_q, ps_d;
   count_t          cnt_q, cnt_d;
   count_t          latch_q, latch_d;
   count_t          disp_d;
   logic            lap_d;
   logic            tick_d;
   logic            running_d;
   logic            wrap;

   // Rising-edge events. The prev flops come out of reset at 1, so a button
   // that is already held when reset releases never produces an event.
   assign ss_ev  = start_stop & ~ss_prev;
   assign clr_ev = clear      & ~clr_prev;
   assign lap_ev = lap        & ~lap_prev;

   // The prescaler only advances while the current state is RUN. The edge that
   // enters RUN does not count, so the first tick lands TICK_DIV cycles later.
   assign wrap = (state_q == ST_RUN) && (ps_q == PS_LAST);

   //---------------------------------------------------------------------------
   // Next-state and next-output logic
   //---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      state_d   = state_q;
      ps_d      = ps_q;
      cnt_d     = cnt_q;
      latch_d   = latch_q;
      lap_d     = lap_active;
      tick_d    = 1'b0;
      running_d = 1'b0;
      disp_d    = cnt_q;

      // Counting uses the state held before this edge. A pause taken on this
      // edge therefore still lets the final RUN cycle advance.
      if (state_q == ST_RUN) begin
         if (wrap) begin
            ps_d   = '0;
            tick_d = 1'b1;
            cnt_d  = next_count(cnt_q);
         end else begin
            ps_d = ps_q + PS_W'(1);
         end
      end

      unique case (state_q)
         ST_IDLE: begin
            // Clear outranks start. In IDLE the count is already zero.
            if (clr_ev) begin
               state_d = ST_IDLE;
               ps_d    = '0;
               cnt_d   = '0;
               lap_d   = 1'b0;
            end else if (ss_ev) begin
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            // Clear has no effect while running. Start/stop outranks lap.
            if (ss_ev) begin
               state_d = ST_PAUSE;
            end else if (lap_ev) begin
               lap_d = ~lap_active;
               // Capture the pre-increment count, even when a tick lands on
               // this same edge.
               if (!lap_active) begin
                  latch_d = cnt_q;
               end
            end
         end

         ST_PAUSE: begin
            // The prescaler is held, so a resume finishes the partial interval.
            if (clr_ev) begin
               state_d = ST_IDLE;
               ps_d    = '0;
               cnt_d   = '0;
               lap_d   = 1'b0;
            end else if (ss_ev) begin
               state_d = ST_RUN;
            end else if (lap_ev && lap_active) begin
               lap_d = 1'b0;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      running_d = (state_d == ST_RUN);
      disp_d    = lap_d ? latch_d : cnt_d;
   end

   //---------------------------------------------------------------------------
   // State and output registers
   //---------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         ss_prev    <= 1'b1;
         clr_prev   <= 1'b1;
         lap_prev   <= 1'b1;
         ps_q       <= '0;
         cnt_q      <= '0;
         latch_q    <= '0;
         lap_active <= 1'b0;
         tick       <= 1'b0;
         running    <= 1'b0;
         digit_hi   <= 4'd0;
         digit_lo   <= 4'd0;
      end else begin
         // NOTE: non-blocking assignments, so every flop samples the values
         // from before this edge, whatever order these statements are in.
         state_q    <= state_d;
         ss_prev    <= start_stop;
         clr_prev   <= clear;
         lap_prev   <= lap;
         ps_q       <= ps_d;
         cnt_q      <= cnt_d;
         latch_q    <= latch_d;
         lap_active <= lap_d;
         tick       <= tick_d;
         running    <= running_d;
         digit_hi   <= disp_d.hi;
         digit_lo   <= disp_d.lo;
      end
   end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Controller that sequences the two-digit counter datapath of the Go board display as a stopwatch. Debounced push-button levels arrive from the switch debouncers. The block edge-detects them and runs a start/pause/clear/lap state machine. It prescales the 25 MHz clock into count ticks and drives a two-digit counter whose nibbles feed the binary-to-7-segment decoders. It owns all counting; the decoders and debouncers stay unchanged.

## Interface
- TICK_DIV, 2500000, clock cycles per count tick (10 Hz at 25 MHz); legal range 2..2^24
- DIGIT_MAX, 9, last value of each digit before wrap (9 = decimal, 15 = hex)
- clock  in  1  main clock, 25 MHz
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- start_stop  in  1  debounced level, rising edge = start/pause toggle
- clear  in  1  debounced level, rising edge = clear request
- lap  in  1  debounced level, rising edge = lap toggle
- digit_lo  out  4  displayed low digit
- digit_hi  out  4  displayed high digit
- running  out  1  high in RUN state
- lap_active  out  1  high while display frozen
- tick  out  1  one-cycle pulse on each count increment

## Operation
- Edge detect: one prev register per input. Prev registers reset to 1, so a button held through reset never produces an event. Event = input & ~prev.
- States: IDLE, RUN, PAUSE. Reset → IDLE, count 00, prescaler 0, lap_active 0, all outputs 0.
- IDLE: start_stop → RUN. Clear → stays IDLE. Lap is ignored.
- RUN: start_stop → PAUSE. Clear is ignored. Lap toggles lap_active; on set, the current count is captured into the display latch.
- PAUSE: start_stop → RUN. Clear → IDLE, which zeroes the count and the prescaler and clears lap_active. Lap, when lap_active=1, clears lap_active; otherwise it is ignored.
- Simultaneous events, in priority order:
  - PAUSE/IDLE: clear beats start_stop. Clear+start in PAUSE → IDLE.
  - RUN: start_stop beats lap; the lap is dropped.
- Prescaler: counts 0..TICK_DIV-1, advancing only in RUN.
  - At TICK_DIV-1 it wraps to 0, asserts tick and increments the count.
  - PAUSE holds the prescaler value, so the partial interval resumes. Only clear or reset zeroes it.
- Count arithmetic, per tick:
  - lo<DIGIT_MAX → lo+1.
  - Otherwise lo→0 and hi increments with the same rule.
  - hi=lo=DIGIT_MAX wraps to 00 and counting continues.
  - Values never exceed DIGIT_MAX.
- Display: digit_hi/digit_lo show the display latch while lap_active=1, otherwise the live count.
- Start_stop→PAUSE while lap_active=1 keeps the latch frozen.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- Input edge sampled at clock edge N:
  - state, running and lap_active change at edge N.
  - Values are visible in the cycle after N.
- Tick: tick is high for exactly the cycle following the edge where the prescaler wraps. The count and the non-lap digit outputs update on that same edge.
- First tick after start arrives TICK_DIV cycles after running rises. After a resume, it arrives TICK_DIV minus the held prescaler value cycles later.
- Lap capture takes the count value present at edge N. If a tick occurs at edge N, the pre-increment value is captured.
- Reset mid-operation: asynchronous return to the reset state regardless of state or prescaler value. No tick is generated on reset release.

## Test plan
- Reset behaviour, with start_stop held high across reset_n release → no start occurs. Expected: running=0, digits 00, tick never asserted.
- Basic counting, TICK_DIV=4, DIGIT_MAX=9: start edge, then 40 cycles. Expected: exactly 10 tick pulses spaced 4 cycles apart, digits hi=1 lo=0.
- Wrap, TICK_DIV=2, DIGIT_MAX=9: run 100 ticks. Expected: digits 99 → 00, running stays 1, tick continues.
- Pause/resume, TICK_DIV=4: pause 6 cycles after start (count 01, prescaler 2); wait 20 cycles; resume. Expected: digits hold 01 throughout the pause, next tick 2 cycles after resume, then digits 02.
- Lap, TICK_DIV=4: lap at count 03. Expected: display holds 03 while live counting continues to 07. Second lap edge → display shows the live 07 next cycle.
- Clear rules:
  - Clear in RUN: ignored, count keeps advancing.
  - Pause then clear: IDLE, digits 00, lap_active=0.
  - Clear+start_stop in the same cycle from PAUSE: IDLE, running=0.
  - reset_n low mid-RUN: immediate 00/IDLE.
